// File: rtl/eda_task_uart_tx.sv
// Serial transmitter that drains the 8-bit eda_task_FIFO: start bit, 8 data
// bits LSB first, optional even parity, one stop bit.
module eda_task_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter bit          PARITY_EN    = 1'b0
) (
   input  logic       SYSCLK,
   input  logic       RST_B,
   input  logic       EMPTY,
   input  logic [7:0] FIFO_DATA,
   output logic       RD_EN,
   output logic       TXD,
   output logic       BUSY,
   output logic       TX_DONE
);

   localparam int unsigned   CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      POP,
      LOAD,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t        state;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift_reg;
   logic          parity_bit;
   logic          txd_q;
   logic          tx_done_q;
   logic          bit_end;

   assign bit_end = (baud_cnt == BAUD_LAST);

   // TXD is loaded one edge ahead of each bit so the line changes exactly on
   // the bit boundary without a decode stage after the register.
   always_ff @(posedge SYSCLK or negedge RST_B) begin
      if (!RST_B) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         parity_bit <= 1'b0;
         txd_q      <= 1'b1;
         tx_done_q  <= 1'b0;
      end else begin
         tx_done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               txd_q <= 1'b1;
               if (!EMPTY) state <= POP;
            end
            POP: begin
               state <= LOAD;
            end
            LOAD: begin
               shift_reg  <= FIFO_DATA;
               parity_bit <= ^FIFO_DATA;
               bit_cnt    <= '0;
               baud_cnt   <= '0;
               txd_q      <= 1'b0;
               state      <= START;
            end
            START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  txd_q    <= shift_reg[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud_cnt  <= '0;
                  shift_reg <= shift_reg >> 1;
                  bit_cnt   <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     if (PARITY_EN) begin
                        txd_q <= parity_bit;
                        state <= PARITY;
                     end else begin
                        txd_q <= 1'b1;
                        state <= STOP;
                     end
                  end else begin
                     txd_q <= shift_reg[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            PARITY: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  txd_q    <= 1'b1;
                  state    <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  baud_cnt  <= '0;
                  tx_done_q <= 1'b1;
                  state     <= EMPTY ? IDLE : POP;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign RD_EN   = (state == POP);
   assign BUSY    = (state != IDLE);
   assign TXD     = txd_q;
   assign TX_DONE = tx_done_q;

endmodule

// File: doc/eda_task_uart_tx.md
# eda_task_uart_tx

Serial transmitter stage that sits directly downstream of the 8-bit `eda_task_FIFO` and drains it. Whenever the FIFO reports non-empty, the block pops one byte and sends it on `TXD` as an asynchronous serial frame: start bit, 8 data bits LSB first, optional even parity, one stop bit. `BUSY` and a one-cycle `TX_DONE` pulse let the rest of the design track progress.

## Interface

- `CLKS_PER_BIT`, 16: `SYSCLK` cycles per serial bit; legal range 2..65535.
- `PARITY_EN`, 0: 1 inserts an even-parity bit between data bit 7 and the stop bit.
- `SYSCLK`  in  1: single clock; all state changes on the rising edge.
- `RST_B`  in  1: reset, asynchronous, active-low.
- `EMPTY`  in  1: FIFO empty flag; connects to the FIFO `EMPTY` output.
- `FIFO_DATA`  in  8: FIFO read data; connects to the FIFO `FIFO_OUT` output. Valid the cycle after `RD_EN` is sampled high.
- `RD_EN`  out  1: FIFO pop request; connects to the FIFO `RD_EN` input.
- `TXD`  out  1: serial line output, idle high, registered.
- `BUSY`  out  1: high in every state except IDLE.
- `TX_DONE`  out  1: one-cycle pulse after each stop bit completes.

## Operation

- States: IDLE, POP, LOAD, START, DATA, PARITY, STOP.
- IDLE: `TXD`=1. If `EMPTY`=0 at the clock edge, go to POP.
- POP: `RD_EN`=1 for exactly this one cycle (decoded from the state). Next state is LOAD unconditionally.
- LOAD: capture `FIFO_DATA` into the 8-bit shift register and clear the bit and baud counters. Next state is START.
- START: `TXD`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA: `TXD`=shift[0]. After `CLKS_PER_BIT` cycles, shift right and increment the bit counter (3 bits). After bit 7, go to PARITY if `PARITY_EN`, otherwise go to STOP.
- PARITY: `TXD`=XOR of the 8 loaded data bits, giving even parity over data plus parity. Lasts `CLKS_PER_BIT` cycles.
- STOP: `TXD`=1 for `CLKS_PER_BIT` cycles. At the final cycle, assert `TX_DONE` on the next cycle and go to POP if `EMPTY`=0, otherwise go to IDLE.
- Baud counter:
  - Width is $clog2(`CLKS_PER_BIT`).
  - Counts 0..`CLKS_PER_BIT`-1 and wraps to 0 at every bit boundary.
  - No drift; every bit is exactly `CLKS_PER_BIT` cycles.
- `EMPTY` is sampled only in IDLE and at the last cycle of STOP. It is ignored in all other states.
- `RD_EN` is never asserted while `EMPTY`=1, so the FIFO is never under-read.
- Reset (any time, including mid-frame):
  - Outputs: `TXD`=1, `RD_EN`=0, `BUSY`=0, `TX_DONE`=0.
  - Internal: state IDLE, all counters 0, shift register 0.
  - A byte that was popped but not fully sent is discarded and is not retransmitted.

## Timing

- Edge k: IDLE samples `EMPTY`=0. After k, `RD_EN`=1 and `BUSY`=1.
- Edge k+1: FIFO pops. After k+1, `RD_EN`=0 and `FIFO_DATA` is valid.
- Edge k+2: data is loaded. After k+2, `TXD`=0 (start of the start bit).
- Frame length F = (10 + `PARITY_EN`) × `CLKS_PER_BIT` cycles. The stop bit ends at edge k+2+F.
- `TX_DONE` is high for the single cycle following edge k+2+F.
- Back-to-back frames: a 2-cycle `TXD`=1 gap (POP and LOAD) follows each stop bit, giving a 2-cycle idle-high stretch between frames. `TX_DONE` overlaps the POP cycle. `BUSY` stays high throughout.
- Single frame: `BUSY` falls in the same cycle `TX_DONE` is high.
- Latency from `EMPTY` falling (sampled in IDLE) to the start bit is 2 cycles.

## Test plan

- **Reset / idle:** hold `RST_B`=0 for 16 ns, then release with `EMPTY`=1 held for 200 cycles.
  - Required: `TXD`=1, `RD_EN`=0, `BUSY`=0, `TX_DONE`=0 throughout.
- **Single byte** (`CLKS_PER_BIT`=4, `PARITY_EN`=0): `EMPTY` low for one pop, `FIFO_DATA`=0xA5.
  - Required: exactly one `RD_EN` pulse.
  - `TXD` sequence is 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
  - `TX_DONE` pulse at cycle k+42.
- **Back-to-back** (`CLKS_PER_BIT`=4): FIFO pre-loaded with 0x01 and 0x02.
  - Required: two frames separated by exactly 2 idle-high cycles.
  - Exactly 2 `RD_EN` pulses and 2 `TX_DONE` pulses.
  - `BUSY` continuous from the first POP to the second `TX_DONE`.
- **Parity** (`PARITY_EN`=1): send 0x07, then 0x03.
  - Required: parity bit 1 for 0x07 and 0 for 0x03.
  - Frame length is 44 cycles at `CLKS_PER_BIT`=4.
- **Reset mid-frame:** assert `RST_B`=0 during data bit 3, asynchronously between edges.
  - Required: `TXD`=1 and `BUSY`=0 immediately, before the next edge.
  - After release with `EMPTY`=1, no retransmission and no `RD_EN`.
- **Integration with `eda_task_FIFO`:** write bytes 1, 2, 3 on alternate cycles while the transmitter runs.
  - Required: bytes are serialized in order 1, 2, 3.
  - FIFO `EMPTY` rises after the third pop.
  - `RD_EN` is never high while `EMPTY`=1.
